// File: rtl/microwave_timer.sv
// microwave_timer: keypad time entry, mm:ss BCD countdown, magnetron enable and done flag.
module microwave_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       done,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  // bit order {door_open, stop, start, pgt_1hz, loadn}; loadn idles high
  localparam logic [4:0] INACTIVE = 5'b00001;
  logic [4:0]  r_sync [SYNC_STAGES];
  logic [4:0]  r_hist;
  logic [4:0]  w_s;
  logic        w_key, w_tick, w_start, w_stop, w_door, w_zero, w_dvalid;
  logic        w_b0, w_b1, w_b2;
  logic [15:0] r_dig, w_ndig, w_dec;
  state_t      r_state, w_nstate;
  logic        r_mag, r_done;
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_key    = r_hist[0] & ~w_s[0];
  assign w_tick   = ~r_hist[1] & w_s[1];
  assign w_start  = ~r_hist[2] & w_s[2];
  assign w_stop   = ~r_hist[3] & w_s[3];
  assign w_door   = w_s[4];
  assign w_zero   = r_dig == 16'd0;
  assign w_dvalid = D <= 4'd9;
  assign w_b0 = r_dig[3:0] == 4'd0;
  assign w_b1 = w_b0 && r_dig[7:4] == 4'd0;
  assign w_b2 = w_b1 && r_dig[11:8] == 4'd0;
  assign w_dec[3:0]   = w_b0 ? 4'd9 : r_dig[3:0] - 4'd1;
  assign w_dec[7:4]   = !w_b0 ? r_dig[7:4] : w_b1 ? 4'd5 : r_dig[7:4] - 4'd1;
  assign w_dec[11:8]  = !w_b1 ? r_dig[11:8] : w_b2 ? 4'd9 : r_dig[11:8] - 4'd1;
  assign w_dec[15:12] = w_b2 ? r_dig[15:12] - 4'd1 : r_dig[15:12];
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= INACTIVE;
      r_hist <= INACTIVE;
    end else begin
      r_sync[0] <= {door_open, stop, start, pgt_1hz, loadn};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= w_s;
    end
  always_comb begin
    w_nstate = r_state;
    w_ndig   = r_dig;
    case (r_state)
      IDLE:
        if (w_stop) w_ndig = 16'd0;
        else if (w_start && !w_zero && !w_door) w_nstate = RUN;
        else if (w_key && w_dvalid) w_ndig = {r_dig[11:0], D};
      RUN:
        if (w_stop || w_door) w_nstate = PAUSE;
        else if (w_tick && !w_zero) begin
          w_ndig   = w_dec;
          w_nstate = w_dec == 16'd0 ? DONE : RUN;
        end
      PAUSE:
        if (w_stop) begin
          w_nstate = IDLE;
          w_ndig   = 16'd0;
        end else if (w_start && !w_door) w_nstate = RUN;
      DONE:
        if (w_stop) begin
          w_nstate = IDLE;
          w_ndig   = 16'd0;
        end else if (w_key && w_dvalid) begin
          w_nstate = IDLE;
          w_ndig   = {12'd0, D};
        end
    endcase
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      r_state <= IDLE;
      r_dig   <= 16'd0;
      r_mag   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_dig   <= w_ndig;
      r_mag   <= w_nstate == RUN;
      r_done  <= w_nstate == DONE;
    end
  assign {min_tens, min_ones, sec_tens, sec_ones} = r_dig;
  assign magnetron_on = r_mag;
  assign done         = r_done;
  assign state        = r_state;
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed and random stimulus against a delay-line event model of the timer.
module tb_microwave_timer;
  localparam int S = 2;
  logic clk = 0, clear = 1, loadn = 1, pgt = 0, start = 0, stop = 0, door = 0;
  logic [3:0] D = 0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic magnetron_on, done;
  logic [1:0] state;
  int errors = 0, checks = 0;
  int mst = 0;
  int dg [4];
  logic [4:0] q [$];
  logic [4:0] c, p;
  logic [19:0] act_v, exp_v;
  microwave_timer #(.SYNC_STAGES(S)) dut (
    .clk(clk), .clear(clear), .D(D), .loadn(loadn), .pgt_1hz(pgt), .start(start),
    .stop(stop), .door_open(door), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .magnetron_on(magnetron_on),
    .done(done), .state(state)
  );
  always #5 clk = ~clk;
  function automatic void mreset();
    mst = 0;
    for (int i = 0; i < 4; i++) dg[i] = 0;
    q.delete();
    for (int i = 0; i <= S; i++) q.push_back(5'b00001);
  endfunction
  function automatic bit mzero();
    return dg[0] == 0 && dg[1] == 0 && dg[2] == 0 && dg[3] == 0;
  endfunction
  function automatic void mclr();
    for (int i = 0; i < 4; i++) dg[i] = 0;
  endfunction
  function automatic void mshift(int d);
    dg[0] = dg[1]; dg[1] = dg[2]; dg[2] = dg[3]; dg[3] = d;
  endfunction
  // time arithmetic on minutes/seconds fields; seconds field may exceed 59 after entry
  function automatic void mdec();
    int m, s;
    m = dg[0] * 10 + dg[1];
    s = dg[2] * 10 + dg[3];
    if (s > 0) s--;
    else begin s = 59; m--; end
    dg[0] = m / 10; dg[1] = m % 10; dg[2] = s / 10; dg[3] = s % 10;
  endfunction
  // events at an edge come from inputs sampled S and S+1 edges earlier
  always @(posedge clk) begin
    if (clear) mreset();
    else begin
      bit key, tick, st, sp, dr;
      q.push_back({door, stop, start, pgt, loadn});
      c = q[q.size()-1-S];
      p = q[q.size()-2-S];
      if (q.size() > S + 2) void'(q.pop_front());
      key = p[0] & ~c[0]; tick = ~p[1] & c[1]; st = ~p[2] & c[2]; sp = ~p[3] & c[3]; dr = c[4];
      case (mst)
        0: if (sp) mclr();
           else if (st && !mzero() && !dr) mst = 1;
           else if (key && D <= 9) mshift(int'(D));
        1: if (sp || dr) mst = 2;
           else if (tick && !mzero()) begin mdec(); if (mzero()) mst = 3; end
        2: if (sp) begin mst = 0; mclr(); end
           else if (st && !dr) mst = 1;
        default: if (sp) begin mst = 0; mclr(); end
           else if (key && D <= 9) begin mst = 0; mclr(); mshift(int'(D)); end
      endcase
    end
    #1;
    act_v = {state, min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done};
    exp_v = {2'(mst), 4'(dg[0]), 4'(dg[1]), 4'(dg[2]), 4'(dg[3]), mst == 1, mst == 3};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
    end
  end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_disp(string nm, int exp);
    chk(nm, min_tens * 1000 + min_ones * 100 + sec_tens * 10 + sec_ones, exp);
  endtask
  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic key(input logic [3:0] d);
    D = d; loadn = 0; wait_n(2); loadn = 1; wait_n(4);
  endtask
  task automatic press_start();
    start = 1; wait_n(2); start = 0; wait_n(4);
  endtask
  task automatic press_stop();
    stop = 1; wait_n(2); stop = 0; wait_n(4);
  endtask
  task automatic tick();
    pgt = 1; wait_n(3); pgt = 0; wait_n(3);
  endtask
  initial begin
    mreset();
    wait_n(2);
    clear = 0;
    wait_n(2);
    chk("reset_state", state, 0);
    key(1); key(2); key(3); key(0);
    chk_disp("entry", 1230);
    chk("entry_state", state, 0);
    key(12);
    chk_disp("bad_digit", 1230);
    press_stop();
    chk_disp("idle_stop", 0);
    key(1); key(0); key(0);
    chk_disp("entry_100", 100);
    press_start();
    chk("run_state", state, 1);
    chk("run_mag", magnetron_on, 1);
    tick();
    chk_disp("first_tick", 59);
    repeat (59) tick();
    chk_disp("count_end", 0);
    chk("done_state", state, 3);
    chk("done_flag", done, 1);
    chk("done_mag", magnetron_on, 0);
    tick();
    chk_disp("extra_tick", 0);
    chk("extra_state", state, 3);
    key(0);
    chk("done_key_state", state, 0);
    key(5);
    press_start();
    tick(); tick();
    chk_disp("pause_pre", 3);
    door = 1; wait_n(4);
    chk("door_pause", state, 2);
    tick();
    chk_disp("pause_tick", 3);
    door = 0; wait_n(4);
    chk("door_closed", state, 2);
    press_start();
    chk("resume", state, 1);
    tick(); tick(); tick();
    chk("resume_done", state, 3);
    chk_disp("resume_disp", 0);
    press_stop();
    key(1); key(0);
    press_start();
    press_stop();
    chk("stop_pause", state, 2);
    chk_disp("stop_keep", 10);
    press_stop();
    chk("stop_idle", state, 0);
    chk_disp("stop_clear", 0);
    press_start();
    chk("start_zero", state, 0);
    key(1); key(0);
    press_start();
    pgt = 1; stop = 1; wait_n(3); pgt = 0; stop = 0; wait_n(3);
    chk("tick_stop_state", state, 2);
    chk_disp("tick_stop_disp", 10);
    press_stop();
    key(4);
    start = 1; stop = 1; wait_n(2); start = 0; stop = 0; wait_n(4);
    chk("start_stop_state", state, 0);
    chk_disp("start_stop_disp", 0);
    key(2); key(1); key(5);
    press_start();
    chk_disp("pre_clear", 215);
    chk("pre_clear_state", state, 1);
    #2 clear = 1;
    #1;
    chk("async_state", state, 0);
    chk_disp("async_disp", 0);
    chk("async_mag", magnetron_on, 0);
    start = 1;
    @(negedge clk);
    clear = 0;
    wait_n(6);
    key(3);
    chk("held_start", state, 0);
    chk_disp("held_disp", 3);
    start = 0; wait_n(4);
    press_start();
    chk("repress", state, 1);
    press_stop(); press_stop();
    repeat (4000) begin
      bit lf;
      @(negedge clk);
      lf = loadn && ($urandom % 6 == 0);
      if (lf) begin loadn = 0; D = 4'($urandom % 10); end
      else if (!loadn && $urandom % 3 == 0) loadn = 1;
      if ($urandom % 3 == 0) pgt = ~pgt;
      if (!lf) begin start = ($urandom % 12 == 0); stop = ($urandom % 40 == 0); end
      if ($urandom % 50 == 0) door = ~door;
      clear = ($urandom % 700 == 0);
    end
    @(negedge clk);
    clear = 0; loadn = 1; start = 0; stop = 0;
    wait_n(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
